// File: rtl/memory_access_unit.sv
// Memory-stage access unit: turns EX/MEM load/store controls into a valid/ready
// data-memory transaction, stalls the pipeline until it completes, and formats load data.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead
// of silently aligning them down.
module memory_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu,
    input  logic [31:0] readData2,
    input  logic [2:0]  func3,
    input  logic        memoryReadEnable,
    input  logic        memoryWriteEnable,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        busError,
    output logic        misalignedTrap,
    output logic [31:0] busAddress,
    output logic [31:0] busWriteData,
    output logic [3:0]  busByteEnable,
    output logic        busWriteEnable,
    output logic        busValid,
    input  logic        busReady,
    input  logic [31:0] busReadData
);

    localparam int unsigned CountWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRequest, StDone} state_e;
    typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} size_e;

    state_e                state_q;
    logic [CountWidth-1:0] counter_q;
    logic [2:0]            op_func3_q;
    logic [1:0]            op_offset_q;
    logic                  op_store_q;

    logic        access;
    logic        is_store;
    logic        trap_hit;
    size_e       access_size;
    logic [1:0]  lane_offset;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] shifted_read;
    logic [31:0] formatted_load;

    // Store wins when both enables are set.
    assign access   = memoryReadEnable | memoryWriteEnable;
    assign is_store = memoryWriteEnable;

    // Decode access size; loads and stores use different func3 maps.
    always_comb begin
        access_size = SizeWord;
        if (is_store) begin
            case (func3)
                3'b000:  access_size = SizeByte;
                3'b001:  access_size = SizeHalf;
                default: access_size = SizeWord;
            endcase
        end else begin
            case (func3)
                3'b000, 3'b100: access_size = SizeByte;
                3'b001, 3'b101: access_size = SizeHalf;
                default:        access_size = SizeWord;
            endcase
        end
    end

    // Lane offset with sub-size address bits forced to zero, plus enables and lane data.
    always_comb begin
        lane_offset = 2'b00;
        byte_enable = 4'b1111;
        write_data  = readData2;
        case (access_size)
            SizeByte: begin
                lane_offset = alu[1:0];
                write_data  = {4{readData2[7:0]}};
            end
            SizeHalf: begin
                lane_offset = {alu[1], 1'b0};
                write_data  = {2{readData2[15:0]}};
            end
            default: begin
                lane_offset = 2'b00;
                write_data  = readData2;
            end
        endcase
        if (is_store) begin
            case (access_size)
                SizeByte: byte_enable = 4'b0001 << lane_offset;
                SizeHalf: byte_enable = 4'b0011 << lane_offset;
                default:  byte_enable = 4'b1111;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;

    // Half needs alu[0]==0, word needs alu[1:0]==0.
    always_comb begin
        misaligned = 1'b0;
        case (access_size)
            SizeHalf: misaligned = alu[0];
            SizeWord: misaligned = (alu[1:0] != 2'b00);
            default:  misaligned = 1'b0;
        endcase
    end

    assign trap_hit = misaligned;
`else
    assign trap_hit = 1'b0;
`endif

    // Extract and extend the addressed byte/half of the returned word.
    always_comb begin
        shifted_read   = busReadData >> {op_offset_q, 3'b000};
        formatted_load = busReadData;
        case (op_func3_q)
            3'b000:  formatted_load = {{24{shifted_read[7]}}, shifted_read[7:0]};
            3'b100:  formatted_load = {24'h0, shifted_read[7:0]};
            3'b001:  formatted_load = {{16{shifted_read[15]}}, shifted_read[15:0]};
            3'b101:  formatted_load = {16'h0, shifted_read[15:0]};
            default: formatted_load = busReadData;
        endcase
    end

    // Stall is combinational so the pipeline freezes in the same cycle the access appears.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (state_q)
                StIdle:    stall = access;
                StRequest: stall = 1'b1;
                default:   stall = 1'b0;
            endcase
        end
    end

    // Access FSM with registered bus fields and result pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            counter_q      <= '0;
            op_func3_q     <= 3'b000;
            op_offset_q    <= 2'b00;
            op_store_q     <= 1'b0;
            busValid       <= 1'b0;
            busAddress     <= 32'h0;
            busWriteData   <= 32'h0;
            busByteEnable  <= 4'h0;
            busWriteEnable <= 1'b0;
            loadData       <= 32'h0;
            loadValid      <= 1'b0;
            busError       <= 1'b0;
            misalignedTrap <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (access) begin
                        if (trap_hit) begin
                            misalignedTrap <= 1'b1;
                            state_q        <= StDone;
                        end else begin
                            busAddress     <= {alu[31:2], 2'b00};
                            busWriteData   <= write_data;
                            busByteEnable  <= byte_enable;
                            busWriteEnable <= is_store;
                            busValid       <= 1'b1;
                            op_func3_q     <= func3;
                            op_offset_q    <= lane_offset;
                            op_store_q     <= is_store;
                            counter_q      <= '0;
                            state_q        <= StRequest;
                        end
                    end
                end
                StRequest: begin
                    if (busValid && busReady) begin
                        if (!op_store_q) begin
                            loadData  <= formatted_load;
                            loadValid <= 1'b1;
                        end
                        busValid  <= 1'b0;
                        counter_q <= '0;
                        state_q   <= StDone;
                    end else if (counter_q == CountLast) begin
                        busValid  <= 1'b0;
                        busError  <= 1'b1;
                        loadData  <= 32'h0;
                        loadValid <= 1'b0;
                        counter_q <= '0;
                        state_q   <= StDone;
                    end else begin
                        counter_q <= counter_q + 1'b1;
                    end
                end
                StDone: begin
                    // Pipeline advances this cycle; never re-issue the same access.
                    loadValid      <= 1'b0;
                    busError       <= 1'b0;
                    misalignedTrap <= 1'b0;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a scoreboard for load/error completions.
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] alu;
    logic [31:0] readData2;
    logic [2:0]  func3;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic        stall;
    logic [31:0] loadData;
    logic        loadValid;
    logic        busError;
    logic        misalignedTrap;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic [3:0]  busByteEnable;
    logic        busWriteEnable;
    logic        busValid;
    logic        busReady;
    logic [31:0] busReadData;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    memory_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .alu               (alu),
        .readData2         (readData2),
        .func3             (func3),
        .memoryReadEnable  (memoryReadEnable),
        .memoryWriteEnable (memoryWriteEnable),
        .stall             (stall),
        .loadData          (loadData),
        .loadValid         (loadValid),
        .busError          (busError),
        .misalignedTrap    (misalignedTrap),
        .busAddress        (busAddress),
        .busWriteData      (busWriteData),
        .busByteEnable     (busByteEnable),
        .busWriteEnable    (busWriteEnable),
        .busValid          (busValid),
        .busReady          (busReady),
        .busReadData       (busReadData)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic err);
        exp_t e;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Scoreboard: every load/error pulse must match the oldest pushed expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1 && (loadValid === 1'b1 || busError === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", {30'h0, busError, loadValid}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("sb_load_data", loadData, e.data);
                check("sb_load_valid", {31'h0, loadValid}, {31'h0, ~e.err});
                check("sb_bus_error", {31'h0, busError}, {31'h0, e.err});
            end
        end
    end

    // One access: drive in IDLE, check held bus fields every REQUEST cycle, release in DONE.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int delay, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input int exp_stall);
        int stall_cycles;
        @(negedge clock);
        alu               = addr;
        readData2         = wdata;
        func3             = f3;
        memoryReadEnable  = rd;
        memoryWriteEnable = wr;
        busReadData       = rdata;
        busReady          = (delay == 0);
        #1;
        check({tag, "_stall_idle"}, {31'h0, stall}, 32'h1);
        stall_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (stall !== 1'b1) break;
            stall_cycles++;
            check({tag, "_bus_valid"}, {31'h0, busValid}, 32'h1);
            check({tag, "_bus_addr"}, busAddress, exp_addr);
            check({tag, "_bus_be"}, {28'h0, busByteEnable}, {28'h0, exp_be});
            check({tag, "_bus_we"}, {31'h0, busWriteEnable}, {31'h0, wr});
            if (wr) check({tag, "_bus_wd"}, busWriteData, exp_wd);
            busReady = ((stall_cycles - 2) >= delay);
        end
        check({tag, "_stall_cycles"}, stall_cycles, exp_stall);
        check({tag, "_done_valid"}, {31'h0, busValid}, 32'h0);
        memoryReadEnable  = 1'b0;
        memoryWriteEnable = 1'b0;
        busReady          = 1'b0;
    endtask

    initial begin
        reset             = 1'b0;
        alu               = 32'h0;
        readData2         = 32'h0;
        func3             = 3'b000;
        memoryReadEnable  = 1'b0;
        memoryWriteEnable = 1'b0;
        busReady          = 1'b0;
        busReadData       = 32'h0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_bus_valid", {31'h0, busValid}, 32'h0);
        check("rst_bus_addr", busAddress, 32'h0);
        check("rst_bus_wd", busWriteData, 32'h0);
        check("rst_bus_be", {28'h0, busByteEnable}, 32'h0);
        check("rst_bus_we", {31'h0, busWriteEnable}, 32'h0);
        check("rst_load_data", loadData, 32'h0);
        check("rst_load_valid", {31'h0, loadValid}, 32'h0);
        check("rst_bus_error", {31'h0, busError}, 32'h0);
        check("rst_trap", {31'h0, misalignedTrap}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b1;

        // LW, ready immediately: 2 stall cycles, 3-cycle latency
        push_exp(32'hDEADBEEF, 1'b0);
        run_access("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                   32'h100, 4'hF, 32'h0, 2);

        // LB / LBU of top byte
        push_exp(32'hFFFFFF80, 1'b0);
        run_access("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0,
                   32'h100, 4'hF, 32'h0, 2);
        push_exp(32'h00000080, 1'b0);
        run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0,
                   32'h100, 4'hF, 32'h0, 2);

        // LH upper half (sign), LHU lower half
        push_exp(32'hFFFF80FF, 1'b0);
        run_access("lh", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1,
                   32'h100, 4'hF, 32'h0, 3);
        push_exp(32'h00001234, 1'b0);
        run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 0,
                   32'h100, 4'hF, 32'h0, 2);

        // SH with 4-cycle ready delay
        run_access("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 4,
                   32'h200, 4'b1100, 32'hABCDABCD, 6);

        // SB lane 1, SW
        run_access("sb", 1'b0, 1'b1, 3'b000, 32'h301, 32'h12345677, 32'h0, 0,
                   32'h300, 4'b0010, 32'h77777777, 2);
        run_access("sw", 1'b0, 1'b1, 3'b010, 32'h400, 32'h11223344, 32'h0, 2,
                   32'h400, 4'b1111, 32'h11223344, 4);

        // Both enables: store wins, no load completion
        run_access("both", 1'b1, 1'b1, 3'b000, 32'h500, 32'h000000A5, 32'h55555555, 0,
                   32'h500, 4'b0001, 32'hA5A5A5A5, 2);

        // Timeout: ready never comes, 16 REQUEST cycles then busError
        push_exp(32'h0, 1'b1);
        run_access("timeout", 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h12345678, 1000,
                   32'h600, 4'hF, 32'h0, 17);

        // Reset mid-REQUEST drops busValid and stall without a clock edge
        @(negedge clock);
        alu              = 32'h700;
        func3            = 3'b010;
        memoryReadEnable = 1'b1;
        busReady         = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_valid_before", {31'h0, busValid}, 32'h1);
        reset = 1'b0;
        #1;
        check("mid_valid_after", {31'h0, busValid}, 32'h0);
        check("mid_stall_after", {31'h0, stall}, 32'h0);
        memoryReadEnable = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        push_exp(32'h0BADF00D, 1'b0);
        run_access("post_rst", 1'b1, 1'b0, 3'b010, 32'h704, 32'h0, 32'h0BADF00D, 0,
                   32'h704, 4'hF, 32'h0, 2);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        @(negedge clock);
        alu              = 32'h101;
        func3            = 3'b010;
        memoryReadEnable = 1'b1;
        #1;
        check("trap_stall_idle", {31'h0, stall}, 32'h1);
        @(negedge clock);
        check("trap_no_valid", {31'h0, busValid}, 32'h0);
        check("trap_pulse", {31'h0, misalignedTrap}, 32'h1);
        check("trap_stall_done", {31'h0, stall}, 32'h0);
        memoryReadEnable = 1'b0;
        @(negedge clock);
        check("trap_pulse_clear", {31'h0, misalignedTrap}, 32'h0);
`else
        push_exp(32'hCAFEF00D, 1'b0);
        run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0,
                   32'h100, 4'hF, 32'h0, 2);
        check("mis_no_trap", {31'h0, misalignedTrap}, 32'h0);
`endif

        @(negedge clock);
        @(negedge clock);
        check("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
